// File: rtl/ram_bus_arbiter_pkg.sv
// Shared constants for the IF/MEM RAM port arbiter: bus widths, one-hot FSM
// state encodings and owner IDs.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
package ram_bus_arbiter_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int DATA_WIDTH = 32;

  // One-hot FSM encodings
  localparam logic [2:0] ARB_IDLE = 3'b001;
  localparam logic [2:0] ARB_ADDR = 3'b010;
  localparam logic [2:0] ARB_DATA = 3'b100;

  // Owner IDs
  localparam logic ARB_OWN_IF  = 1'b0;
  localparam logic ARB_OWN_MEM = 1'b1;

endpackage

// File: rtl/ram_bus_arbiter_arb_pick.sv
// Combinational winner selection between the IF and MEM requesters.
// With ARB_ROUND_ROBIN_EN defined a tie goes to the requester that was not
// granted last; otherwise MEM always beats IF.
module arb_pick
  import ram_bus_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic mem_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority has no history to consult
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;
`endif

  // Pick a winner from the requests currently raised
  always_comb begin
    grant_valid = if_req | mem_req;
    grant_id    = ARB_OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && mem_req) begin
      grant_id = (last_grant == ARB_OWN_IF) ? ARB_OWN_MEM : ARB_OWN_IF;
    end else if (mem_req) begin
      grant_id = ARB_OWN_MEM;
    end
`else
    if (mem_req) begin
      grant_id = ARB_OWN_MEM;
    end
`endif
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one SRAM-like RAM port between instruction fetch (IF) and
// load/store (MEM). One transaction in flight; responses are steered to the
// owner only and dropped when the owner's stage is flushed.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking
// (adds the last_grant flop); default is fixed MEM > IF priority.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [BUS_WIDTH-1:0]  if_addr,
  input  logic                  if_cancel,
  output logic                  if_addr_ok,
  output logic                  if_data_ok,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [3:0]            mem_wstrb,
  input  logic [BUS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_cancel,
  output logic                  mem_addr_ok,
  output logic                  mem_data_ok,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ram_req,
  output logic                  ram_wr,
  output logic [3:0]            ram_wstrb,
  output logic [BUS_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_addr_ok,
  input  logic                  ram_data_ok,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [2:0]            r_state;
  logic                  r_owner;
  logic                  r_drop;
  logic                  r_ram_req;
  logic                  r_ram_wr;
  logic [3:0]            r_ram_wstrb;
  logic [BUS_WIDTH-1:0]  r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;

  logic w_last_grant;
  logic w_grant_valid;
  logic w_grant_id;
  logic w_win_mem;
  logic w_accept;
  logic w_done;
  logic w_grant;
  logic w_owner_cancel;
  logic w_forward;

  arb_pick u_pick (
    .if_req      (if_req),
    .mem_req     (mem_req),
    .last_grant  (w_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // Grant points are IDLE and the response cycle of DATA, so back-to-back
  // transactions need no idle bubble.
  assign w_accept       = (r_state == ARB_ADDR) && ram_addr_ok;
  assign w_done         = (r_state == ARB_DATA) && ram_data_ok;
  assign w_grant        = ((r_state == ARB_IDLE) || w_done) && w_grant_valid;
  assign w_win_mem      = (w_grant_id == ARB_OWN_MEM);
  assign w_owner_cancel = (r_owner == ARB_OWN_MEM) ? mem_cancel : if_cancel;
  // A cancel on the response cycle itself still suppresses the ack
  assign w_forward      = w_done && !r_drop && !w_owner_cancel;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Remember who won most recently so the next tie goes the other way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= ARB_OWN_IF;
    end else if (w_grant) begin
      r_last_grant <= w_grant_id;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = ARB_OWN_IF;
`endif

  // Transaction FSM, owner and drop tracking; a new grant overrides the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= ARB_OWN_IF;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: ;
        ARB_ADDR: begin
          if (ram_addr_ok) r_state <= ARB_DATA;
          if (w_owner_cancel) r_drop <= 1'b1;
        end
        ARB_DATA: begin
          if (ram_data_ok) r_state <= ARB_IDLE;
          if (w_owner_cancel) r_drop <= 1'b1;
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (w_grant) begin
        r_state <= ARB_ADDR;
        r_owner <= w_grant_id;
        r_drop  <= 1'b0;
      end
    end
  end

  // Registered RAM command: captured at grant, held stable until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_req   <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_wstrb <= 4'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_grant) begin
      r_ram_req   <= 1'b1;
      r_ram_wr    <= w_win_mem & mem_wr;
      r_ram_wstrb <= w_win_mem ? mem_wstrb : 4'b0;
      r_ram_addr  <= w_win_mem ? mem_addr : if_addr;
      r_ram_wdata <= w_win_mem ? mem_wdata : '0;
    end else if (w_accept) begin
      r_ram_req   <= 1'b0;
    end
  end

  assign ram_req     = r_ram_req;
  assign ram_wr      = r_ram_wr;
  assign ram_wstrb   = r_ram_wstrb;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;

  // Handshake pulses reach only the owner; read data is a plain pass-through
  assign if_addr_ok  = w_accept && (r_owner == ARB_OWN_IF);
  assign mem_addr_ok = w_accept && (r_owner == ARB_OWN_MEM);
  assign if_data_ok  = w_forward && (r_owner == ARB_OWN_IF);
  assign mem_data_ok = w_forward && (r_owner == ARB_OWN_MEM);
  assign if_rdata    = ram_rdata;
  assign mem_rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_ram_bus_arbiter;
  import ram_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_cancel, mem_req, mem_wr, mem_cancel;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_wstrb;
  logic        ram_addr_ok, ram_data_ok;
  logic        if_addr_ok, if_data_ok, mem_addr_ok, mem_data_ok;
  logic [31:0] if_rdata, mem_rdata;
  logic        ram_req, ram_wr;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_addr, ram_wdata;

  always #5 clk = ~clk;

  ram_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_addr_ok(if_addr_ok), .if_data_ok(if_data_ok), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cancel(mem_cancel),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_wstrb(ram_wstrb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Combinational outputs captured mid-cycle by tick()
  logic        c_if_aok, c_if_dok, c_mem_aok, c_mem_dok;
  logic [31:0] c_if_rdata, c_mem_rdata;

  // Transaction-level reference model
  typedef struct packed {
    logic busy;
    logic sent;
    logic owner_mem;
    logic drop;
  } txn_t;

  txn_t        cur;
  logic        m_last_mem;
  logic        m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  bit          model_on = 1'b0;

  task automatic model_reset();
    cur        = '0;
    m_last_mem = 1'b0;
    m_wr       = 1'b0;
    m_wstrb    = 4'b0;
    m_addr     = '0;
    m_wdata    = '0;
  endtask

  task automatic model_step();
    logic acc_now, resp_now, own_cancel, deliver, pick_mem;
    acc_now    = cur.busy && !cur.sent && ram_addr_ok;
    resp_now   = cur.busy && cur.sent && ram_data_ok;
    own_cancel = cur.owner_mem ? mem_cancel : if_cancel;
    deliver    = resp_now && !cur.drop && !own_cancel;
    chk1("rnd_if_addr_ok",  c_if_aok,  acc_now && !cur.owner_mem);
    chk1("rnd_mem_addr_ok", c_mem_aok, acc_now && cur.owner_mem);
    chk1("rnd_if_data_ok",  c_if_dok,  deliver && !cur.owner_mem);
    chk1("rnd_mem_data_ok", c_mem_dok, deliver && cur.owner_mem);
    if (deliver)
      chk32("rnd_rdata", cur.owner_mem ? c_mem_rdata : c_if_rdata, ram_rdata);
    if (cur.busy && own_cancel) cur.drop = 1'b1;
    if (acc_now) cur.sent = 1'b1;
    if (resp_now) cur.busy = 1'b0;
    if (!cur.busy && (if_req || mem_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_mem = (if_req && mem_req) ? !m_last_mem : mem_req;
`else
      pick_mem = mem_req;
`endif
      m_last_mem    = pick_mem;
      cur.busy      = 1'b1;
      cur.sent      = 1'b0;
      cur.owner_mem = pick_mem;
      cur.drop      = 1'b0;
      m_wr    = pick_mem & mem_wr;
      m_wstrb = pick_mem ? mem_wstrb : 4'b0;
      m_addr  = pick_mem ? mem_addr : if_addr;
      m_wdata = pick_mem ? mem_wdata : 32'h0;
    end
  endtask

  task automatic model_check_regs();
    chk1("rnd_ram_req",    ram_req, cur.busy && !cur.sent);
    chk1("rnd_ram_wr",     ram_wr, m_wr);
    chk32("rnd_ram_wstrb", {28'h0, ram_wstrb}, {28'h0, m_wstrb});
    chk32("rnd_ram_addr",  ram_addr, m_addr);
    chk32("rnd_ram_wdata", ram_wdata, m_wdata);
  endtask

  // One clock: inputs already set; sample comb at negedge, regs 1 after posedge
  task automatic tick();
    @(negedge clk);
    c_if_aok    = if_addr_ok;
    c_if_dok    = if_data_ok;
    c_mem_aok   = mem_addr_ok;
    c_mem_dok   = mem_data_ok;
    c_if_rdata  = if_rdata;
    c_mem_rdata = mem_rdata;
    if (model_on) model_step();
    @(posedge clk);
    #1;
    if (model_on) model_check_regs();
  endtask

  task automatic clear_inputs();
    if_req = 0; if_cancel = 0; if_addr = '0;
    mem_req = 0; mem_wr = 0; mem_wstrb = '0; mem_addr = '0; mem_wdata = '0; mem_cancel = 0;
    ram_addr_ok = 0; ram_data_ok = 0; ram_rdata = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Directed vector table
  typedef struct {
    logic ifr, memr, aok, dok;
    logic [31:0] rdata;
    logic e_if_aok, e_if_dok, e_mem_aok, e_mem_dok, e_req;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic ifr, input logic memr, input logic aok,
                              input logic dok, input logic [31:0] rd,
                              input logic eia, input logic eid, input logic ema,
                              input logic emd, input logic ereq, input logic [31:0] ea);
    vec_t v;
    v.ifr = ifr; v.memr = memr; v.aok = aok; v.dok = dok; v.rdata = rd;
    v.e_if_aok = eia; v.e_if_dok = eid; v.e_mem_aok = ema; v.e_mem_dok = emd;
    v.e_req = ereq; v.e_addr = ea;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit if_pend, mem_pend, exp_mem;

    // IF read 0x100 alone, then IF+MEM tie, then stray RAM responses in IDLE
    tbl[0]  = mk(1,0,0,0,32'h0,        0,0,0,0, 1,32'h100);
    tbl[1]  = mk(1,0,0,0,32'h0,        0,0,0,0, 1,32'h100);
    tbl[2]  = mk(1,0,1,0,32'h0,        1,0,0,0, 0,32'h100);
    tbl[3]  = mk(0,0,0,0,32'h0,        0,0,0,0, 0,32'h100);
    tbl[4]  = mk(0,0,0,1,32'hDEADBEEF, 0,1,0,0, 0,32'h100);
    tbl[5]  = mk(0,0,0,0,32'h0,        0,0,0,0, 0,32'h100);
    tbl[6]  = mk(1,1,0,0,32'h0,        0,0,0,0, 1,32'h200);
    tbl[7]  = mk(1,1,1,0,32'h0,        0,0,1,0, 0,32'h200);
    tbl[8]  = mk(1,0,0,1,32'h11,       0,0,0,1, 1,32'h100);
    tbl[9]  = mk(1,0,1,0,32'h0,        1,0,0,0, 0,32'h100);
    tbl[10] = mk(0,0,0,0,32'h0,        0,0,0,0, 0,32'h100);
    tbl[11] = mk(0,0,0,1,32'h22,       0,1,0,0, 0,32'h100);
    tbl[12] = mk(0,0,1,0,32'h0,        0,0,0,0, 0,32'h100);
    tbl[13] = mk(0,0,0,1,32'h33,       0,0,0,0, 0,32'h100);

    // Reset values, including stray RAM handshakes while idle
    reset_dut();
    ram_addr_ok = 1; ram_data_ok = 1; ram_rdata = 32'h55;
    #1;
    chk1("rst_ram_req", ram_req, 1'b0);
    chk1("rst_ram_wr", ram_wr, 1'b0);
    chk32("rst_ram_wstrb", {28'h0, ram_wstrb}, 32'h0);
    chk32("rst_ram_addr", ram_addr, 32'h0);
    chk32("rst_ram_wdata", ram_wdata, 32'h0);
    chk1("rst_if_addr_ok", if_addr_ok, 1'b0);
    chk1("rst_if_data_ok", if_data_ok, 1'b0);
    chk1("rst_mem_addr_ok", mem_addr_ok, 1'b0);
    chk1("rst_mem_data_ok", mem_data_ok, 1'b0);
    ram_addr_ok = 0; ram_data_ok = 0;

    // Table run
    if_addr = 32'h100; mem_addr = 32'h200;
    for (int i = 0; i < 14; i++) begin
      if_req = tbl[i].ifr; mem_req = tbl[i].memr;
      ram_addr_ok = tbl[i].aok; ram_data_ok = tbl[i].dok; ram_rdata = tbl[i].rdata;
      tick();
      chk1($sformatf("tbl%0d_if_addr_ok", i), c_if_aok, tbl[i].e_if_aok);
      chk1($sformatf("tbl%0d_if_data_ok", i), c_if_dok, tbl[i].e_if_dok);
      chk1($sformatf("tbl%0d_mem_addr_ok", i), c_mem_aok, tbl[i].e_mem_aok);
      chk1($sformatf("tbl%0d_mem_data_ok", i), c_mem_dok, tbl[i].e_mem_dok);
      if (tbl[i].e_if_dok) chk32($sformatf("tbl%0d_if_rdata", i), c_if_rdata, tbl[i].rdata);
      if (tbl[i].e_mem_dok) chk32($sformatf("tbl%0d_mem_rdata", i), c_mem_rdata, tbl[i].rdata);
      chk1($sformatf("tbl%0d_ram_req", i), ram_req, tbl[i].e_req);
      chk32($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].e_addr);
    end

    // Both requesters permanently high: grant order at each tie
    reset_dut();
    if_addr = 32'h100; mem_addr = 32'h200; if_req = 1; mem_req = 1;
    tick();
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_mem = (g % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      ram_addr_ok = 1; ram_data_ok = 0;
      tick();
      chk1($sformatf("tie%0d_mem_addr_ok", g), c_mem_aok, exp_mem);
      chk1($sformatf("tie%0d_if_addr_ok", g), c_if_aok, !exp_mem);
      ram_addr_ok = 0; ram_data_ok = 1; ram_rdata = 32'hA0 + g;
      tick();
      chk1($sformatf("tie%0d_mem_data_ok", g), c_mem_dok, exp_mem);
      chk1($sformatf("tie%0d_if_data_ok", g), c_if_dok, !exp_mem);
      chk1($sformatf("tie%0d_ram_req_next", g), ram_req, 1'b1);
    end

    // Cancelled MEM write: RAM still gets the command, ack is dropped
    reset_dut();
    mem_req = 1; mem_wr = 1; mem_wstrb = 4'hF; mem_addr = 32'h200; mem_wdata = 32'h12345678;
    tick();
    chk1("wr_ram_req", ram_req, 1'b1);
    chk1("wr_ram_wr", ram_wr, 1'b1);
    chk32("wr_ram_wstrb", {28'h0, ram_wstrb}, 32'hF);
    chk32("wr_ram_addr", ram_addr, 32'h200);
    chk32("wr_ram_wdata", ram_wdata, 32'h12345678);
    ram_addr_ok = 1;
    tick();
    chk1("wr_mem_addr_ok", c_mem_aok, 1'b1);
    mem_req = 0; mem_addr = 32'hFFF0; mem_wdata = 32'h0; ram_addr_ok = 0; mem_cancel = 1;
    tick();
    chk1("wr_cancel_data_ok", c_mem_dok, 1'b0);
    chk32("wr_ram_addr_held", ram_addr, 32'h200);
    mem_cancel = 0; ram_data_ok = 1;
    tick();
    chk1("wr_dropped_data_ok", c_mem_dok, 1'b0);
    chk1("wr_if_data_ok", c_if_dok, 1'b0);
    ram_data_ok = 0;
    tick();
    chk1("wr_idle_ram_req", ram_req, 1'b0);

    // IF cancel on the response cycle, MEM granted in that same cycle
    reset_dut();
    if_req = 1; if_addr = 32'h100;
    tick();
    ram_addr_ok = 1;
    tick();
    chk1("cx_if_addr_ok", c_if_aok, 1'b1);
    if_req = 0; ram_addr_ok = 0;
    tick();
    ram_data_ok = 1; if_cancel = 1; ram_rdata = 32'hCAFE;
    mem_req = 1; mem_wr = 0; mem_addr = 32'h240;
    tick();
    chk1("cx_if_data_ok", c_if_dok, 1'b0);
    chk1("cx_next_ram_req", ram_req, 1'b1);
    chk32("cx_next_ram_addr", ram_addr, 32'h240);
    if_cancel = 0; ram_data_ok = 0; ram_addr_ok = 1;
    tick();
    chk1("cx_mem_addr_ok", c_mem_aok, 1'b1);
    mem_req = 0; ram_addr_ok = 0; ram_data_ok = 1; ram_rdata = 32'h5A5A;
    tick();
    chk1("cx_mem_data_ok", c_mem_dok, 1'b1);
    chk32("cx_mem_rdata", c_mem_rdata, 32'h5A5A);

    // Reset while in DATA, then a stray response
    reset_dut();
    if_req = 1; if_addr = 32'h300;
    tick();
    ram_addr_ok = 1;
    tick();
    chk1("rm_if_addr_ok", c_if_aok, 1'b1);
    if_req = 0; ram_addr_ok = 0;
    #2;
    rst_n = 0; ram_data_ok = 1; ram_rdata = 32'hBAD;
    #1;
    chk1("rm_if_data_ok_in_reset", if_data_ok, 1'b0);
    chk1("rm_ram_req_in_reset", ram_req, 1'b0);
    chk32("rm_ram_addr_in_reset", ram_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    chk1("rm_stray_if_data_ok", c_if_dok, 1'b0);
    chk1("rm_stray_mem_data_ok", c_mem_dok, 1'b0);
    chk1("rm_stray_ram_req", ram_req, 1'b0);
    ram_data_ok = 0; if_req = 1;
    tick();
    chk1("rm_regrant_ram_req", ram_req, 1'b1);
    chk32("rm_regrant_ram_addr", ram_addr, 32'h300);

    // Randomized run against the model
    reset_dut();
    model_reset();
    model_on = 1'b1;
    if_pend = 0; mem_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!if_pend) begin
        if_addr = $urandom;
        if ($urandom_range(0, 2) == 0) if_pend = 1;
      end
      if (!mem_pend) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wr    = 1'($urandom_range(0, 1));
        mem_wstrb = 4'($urandom);
        if ($urandom_range(0, 2) == 0) mem_pend = 1;
      end
      if_req      = if_pend;
      mem_req     = mem_pend;
      if_cancel   = ($urandom_range(0, 7) == 0);
      mem_cancel  = ($urandom_range(0, 7) == 0);
      ram_addr_ok = 1'($urandom_range(0, 1));
      ram_data_ok = 1'($urandom_range(0, 1));
      ram_rdata   = $urandom;
      tick();
      if (c_if_aok) if_pend = 0;
      if (c_mem_aok) mem_pend = 0;
    end
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
